boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_pkg.sv | 24 ++
 rtl/boot_loader_uart_rx.sv | 102 ++++++++++
 rtl/boot_loader.sv | 163 ++++++++++++++++
 tb/tb_boot_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader: framing FSM states,
// receiver states and the frame header byte.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        RUN,
        ERR
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] BOOT_HEADER = 8'hA5;

endpackage

// File: rtl/boot_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit start qualification and
// sampling, single-cycle rx_valid pulse. Framing errors drop the byte silently.
module uart_rx
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);

    localparam int CNT_W = ($clog2(CLKS_PER_BIT) > 0) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic [7:0]       byte_q, byte_d;
    logic             rx_s;

    assign rx_s     = sync_q[1];
    assign rx_valid = valid_q;
    assign rx_byte  = byte_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        byte_d  = byte_q;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            // A glitch shorter than half a bit falls back to idle here.
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_BITS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_BITS: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            byte_q  <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            byte_q  <= byte_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Serial boot loader: parses A5/count/data/checksum frames from the UART,
// writes words into instruction memory and releases the CPU on success.
module boot_loader
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int IMEM_WORDS   = 256,
    parameter int TIMEOUT      = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        error
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [16:0]      MAX_WORDS = 17'(IMEM_WORDS);

    logic        rx_valid;
    logic [7:0]  rx_byte;

    boot_state_t      state_q, state_d;
    logic [15:0]      count_q, count_d;
    logic [15:0]      word_idx_q, word_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      word_q, word_d;
    logic [7:0]       csum_q, csum_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             imem_we_q, imem_we_d;
    logic [31:0]      imem_addr_q, imem_addr_d;
    logic [31:0]      imem_wdata_q, imem_wdata_d;
    logic             cpu_rst_n_q, cpu_rst_n_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             timeout;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (uart_rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte)
    );

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign done       = done_q;
    assign error      = error_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        csum_d       = csum_q;
        timer_d      = '0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        timeout      = 1'b0;

        // Inter-byte watchdog, only armed while a frame is in progress.
        if (state_q inside {LEN_LO, LEN_HI, DATA, CHECK}) begin
            if (rx_valid)                 timer_d = '0;
            else if (timer_q == TMR_LAST) timeout = 1'b1;
            else                          timer_d = timer_q + 1'b1;
        end

        case (state_q)
            IDLE, ERR: begin
                if (rx_valid && rx_byte == BOOT_HEADER) begin
                    state_d    = LEN_LO;
                    csum_d     = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    count_d[7:0] = rx_byte;
                    state_d      = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    count_d = {rx_byte, count_q[7:0]};
                    if ({1'b0, rx_byte, count_q[7:0]} > MAX_WORDS) state_d = ERR;
                    else if ({rx_byte, count_q[7:0]} == 16'd0)     state_d = CHECK;
                    else                                           state_d = DATA;
                end
            end
            // Leave only after the final write strobe so imem_we never shows outside DATA.
            DATA: begin
                if (imem_we_q && word_idx_q == count_q) begin
                    state_d = CHECK;
                end else if (rx_valid) begin
                    csum_d     = csum_q ^ rx_byte;
                    word_d     = {rx_byte, word_q[31:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = {14'd0, word_idx_q, 2'b00};
                        imem_wdata_d = {rx_byte, word_q[31:8]};
                        word_idx_d   = word_idx_q + 16'd1;
                    end
                end
            end
            CHECK: begin
                if (rx_valid) state_d = (rx_byte == csum_q) ? RUN : ERR;
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (timeout) state_d = ERR;

        done_d      = (state_d == RUN);
        cpu_rst_n_d = (state_d == RUN);
        error_d     = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            timer_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_n_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            csum_q       <= csum_d;
            timer_q      <= timer_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed frames plus randomized frames
// compared against a frame-level model of the expected writes and final status.
module tb_boot_loader;

    localparam int CPB = 4;
    localparam int TMO = 200;
    localparam int NW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    always #5 clk = ~clk;

    boot_loader #(.CLKS_PER_BIT(CPB), .IMEM_WORDS(NW), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .error      (error)
    );

    // Every sampled strobe cycle is logged, so a stretched pulse shows as a duplicate write.
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_tx();
        foreach (tx[i]) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_byte(tx[i], 1'b1);
        end
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (imem_we !== 1'b0)     begin errors++; $display("FAIL reset_we got %b exp 0", imem_we); end
        checks++; if (imem_addr !== 32'h0)  begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", imem_wdata); end
        checks++; if (cpu_rst_n !== 1'b0)   begin errors++; $display("FAIL reset_cpu_rst_n got %b exp 0", cpu_rst_n); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (error !== 1'b0)       begin errors++; $display("FAIL reset_error got %b exp 0", error); end
        rst = 1'b0;
    endtask

    task automatic test_valid_frame();
        do_reset();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_tx();
        settle();
        exp_addr = '{32'h0, 32'h4};
        exp_data = '{32'h0000_0013, 32'h0010_0093};
        checks++; if (got_addr.size() !== 2) begin errors++; $display("FAIL valid_nwrites got %0d exp 2", got_addr.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < got_addr.size()) begin
                checks++; if (got_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL valid_addr%0d got %h exp %h", i, got_addr[i], exp_addr[i]); end
                checks++; if (got_data[i] !== exp_data[i]) begin errors++; $display("FAIL valid_data%0d got %h exp %h", i, got_data[i], exp_data[i]); end
            end
        end
        checks++; if (done !== 1'b1)      begin errors++; $display("FAIL valid_done got %b exp 1", done); end
        checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL valid_cpu_rst_n got %b exp 1", cpu_rst_n); end
        checks++; if (error !== 1'b0)     begin errors++; $display("FAIL valid_error got %b exp 0", error); end
        // A later header while running must be ignored.
        tx = '{8'hA5, 8'h01};
        send_tx();
        settle();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_ignore_done got %b exp 1", done); end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        send_tx();
        settle();
        checks++; if (error !== 1'b1)     begin errors++; $display("FAIL badsum_error got %b exp 1", error); end
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL badsum_cpu_rst_n got %b exp 0", cpu_rst_n); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL badsum_done got %b exp 0", done); end
    endtask

    task automatic test_oversize();
        do_reset();
        tx = '{8'hA5, 8'h05, 8'h00};
        send_tx();
        settle();
        checks++; if (error !== 1'b1)        begin errors++; $display("FAIL oversize_error got %b exp 1", error); end
        checks++; if (got_addr.size() !== 0) begin errors++; $display("FAIL oversize_nwrites got %0d exp 0", got_addr.size()); end
    endtask

    task automatic test_zero_count();
        do_reset();
        tx = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_tx();
        settle();
        checks++; if (done !== 1'b1)         begin errors++; $display("FAIL zero_done got %b exp 1", done); end
        checks++; if (cpu_rst_n !== 1'b1)    begin errors++; $display("FAIL zero_cpu_rst_n got %b exp 1", cpu_rst_n); end
        checks++; if (got_addr.size() !== 0) begin errors++; $display("FAIL zero_nwrites got %0d exp 0", got_addr.size()); end
    endtask

    task automatic test_timeout();
        do_reset();
        tx = '{8'hA5, 8'h01, 8'h00, 8'h13};
        send_tx();
        repeat (170) @(negedge clk);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", error); end
        repeat (60) @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error got %b exp 1", error); end
        // Recovery from ERR with a fresh frame; word index restarts at 0.
        tx = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_tx();
        settle();
        checks++; if (done !== 1'b1)  begin errors++; $display("FAIL timeout_recover_done got %b exp 1", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_recover_error got %b exp 0", error); end
        checks++; if (got_addr.size() !== 1) begin errors++; $display("FAIL timeout_nwrites got %0d exp 1", got_addr.size()); end
        else begin
            checks++; if (got_addr[0] !== 32'h0)         begin errors++; $display("FAIL timeout_addr got %h exp 0", got_addr[0]); end
            checks++; if (got_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL timeout_data got %h exp deadbeef", got_data[0]); end
        end
    endtask

    task automatic test_bad_stop();
        do_reset();
        send_byte(8'hA5, 1'b0);
        repeat (60) @(negedge clk);
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_tx();
        settle();
        checks++; if (done !== 1'b1)         begin errors++; $display("FAIL badstop_done got %b exp 1", done); end
        checks++; if (got_addr.size() !== 2) begin errors++; $display("FAIL badstop_nwrites got %0d exp 2", got_addr.size()); end
    endtask

    task automatic test_rst_mid_data();
        do_reset();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
        send_tx();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (imem_we !== 1'b0)     begin errors++; $display("FAIL midrst_we got %b exp 0", imem_we); end
        checks++; if (imem_addr !== 32'h0)  begin errors++; $display("FAIL midrst_addr got %h exp 0", imem_addr); end
        checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL midrst_wdata got %h exp 0", imem_wdata); end
        checks++; if (cpu_rst_n !== 1'b0)   begin errors++; $display("FAIL midrst_cpu_rst_n got %b exp 0", cpu_rst_n); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL midrst_done got %b exp 0", done); end
        checks++; if (error !== 1'b0)       begin errors++; $display("FAIL midrst_error got %b exp 0", error); end
        rst = 1'b0;
        tx = '{8'h00, 8'h10, 8'h00, 8'h90};
        send_tx();
        settle();
        checks++; if (got_addr.size() !== 1) begin errors++; $display("FAIL midrst_nwrites got %0d exp 1", got_addr.size()); end
        checks++; if (done !== 1'b0)         begin errors++; $display("FAIL midrst_after_done got %b exp 0", done); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int          mode;
            int          count;
            logic [7:0]  csum;
            logic [7:0]  jb;
            logic [31:0] w;
            logic        exp_done;
            logic        exp_err;
            do_reset();
            mode  = $urandom_range(0, 3);
            count = (mode == 0) ? NW + 1 + $urandom_range(0, 300) : $urandom_range(0, NW);
            tx.delete();
            exp_addr.delete();
            exp_data.delete();
            repeat ($urandom_range(0, 2)) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h5A;
                tx.push_back(jb);
            end
            tx.push_back(8'hA5);
            tx.push_back(8'(count));
            tx.push_back(8'(count >> 8));
            csum = 8'h00;
            if (mode != 0) begin
                for (int k = 0; k < count; k++) begin
                    w = $urandom;
                    exp_addr.push_back(32'(4 * k));
                    exp_data.push_back(w);
                    for (int b = 0; b < 4; b++) begin
                        tx.push_back(w[8*b +: 8]);
                        csum = csum ^ w[8*b +: 8];
                    end
                end
                tx.push_back((mode == 1) ? (csum ^ 8'($urandom_range(1, 255))) : csum);
            end
            exp_done = (mode >= 2);
            exp_err  = !exp_done;
            send_tx();
            settle();
            checks++; if (done !== exp_done) begin errors++; $display("FAIL rand%0d_done got %b exp %b", it, done, exp_done); end
            checks++; if (error !== exp_err) begin errors++; $display("FAIL rand%0d_error got %b exp %b", it, error, exp_err); end
            checks++; if (cpu_rst_n !== exp_done) begin errors++; $display("FAIL rand%0d_cpu_rst_n got %b exp %b", it, cpu_rst_n, exp_done); end
            checks++; if (got_addr.size() !== exp_addr.size()) begin
                errors++; $display("FAIL rand%0d_nwrites got %0d exp %0d", it, got_addr.size(), exp_addr.size());
            end else begin
                foreach (exp_addr[i]) begin
                    checks++; if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                        errors++; $display("FAIL rand%0d_write%0d got %h:%h exp %h:%h", it, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_oversize();
        test_zero_count();
        test_timeout();
        test_bad_stop();
        test_rst_mid_data();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
